// File: rtl/ltc2195_pkg.sv
// Shared types and constants for the LTC2195 frame alignment controller.
package ltc2195_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SLIP,
      SETTLE,
      VERIFY,
      LOCKED,
      FAIL
   } state_e;

   localparam logic [7:0] FR_PATTERN_DEFAULT = 8'hF0;
   localparam int         SLIP_CNT_W         = 4;

endpackage

// File: rtl/ltc2195_frame_align_if.sv
// Frame-word / bitslip link between the LTC2195 driver side and the aligner.
interface ltc2195_frame_align_if;
   import ltc2195_pkg::*;

   logic                  en_in;
   logic                  realign_in;
   logic [7:0]            FR_in;
   logic                  bitslip_out;
   logic                  locked_out;
   logic                  fail_out;
   logic [SLIP_CNT_W-1:0] slip_count_out;

   // master: the side supplying frame words and control (driver / system)
   modport master (
      output en_in, realign_in, FR_in,
      input  bitslip_out, locked_out, fail_out, slip_count_out
   );

   // slave: the alignment controller itself
   modport slave (
      input  en_in, realign_in, FR_in,
      output bitslip_out, locked_out, fail_out, slip_count_out
   );

endinterface

// File: rtl/ltc2195_frame_align.sv
// Bitslip alignment FSM: pulses bitslip until the deserialized frame word
// equals FR_PATTERN, confirms lock, and re-aligns on sustained loss.
module ltc2195_frame_align
   import ltc2195_pkg::*;
#(
   parameter logic [7:0] FR_PATTERN    = FR_PATTERN_DEFAULT,
   parameter int         SETTLE_CYCLES = 4,
   parameter int         MAX_SLIPS     = 8,
   parameter int         LOCK_COUNT    = 16,
   parameter int         LOSS_COUNT    = 4
) (
   input logic                 clk_in,
   input logic                 rst_in,
   ltc2195_frame_align_if.slave fa
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);

   state_e                state_q, state_d;
   logic [SLIP_CNT_W-1:0] slip_cnt_q, slip_cnt_d;
   logic [3:0]            settle_cnt_q, settle_cnt_d;
   logic [MW-1:0]         match_cnt_q, match_cnt_d;
   logic [LW-1:0]         miss_cnt_q, miss_cnt_d;
   logic                  bitslip_q, bitslip_d;
   logic                  locked_q, locked_d;
   logic                  fail_q, fail_d;
   logic                  match;

   assign match = (fa.FR_in == FR_PATTERN);

   always_comb begin
      state_d      = state_q;
      slip_cnt_d   = slip_cnt_q;
      settle_cnt_d = settle_cnt_q;
      match_cnt_d  = match_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      bitslip_d    = 1'b0;
      locked_d     = locked_q;
      fail_d       = fail_q;

      if (!fa.en_in) begin
         state_d      = IDLE;
         slip_cnt_d   = '0;
         settle_cnt_d = '0;
         match_cnt_d  = '0;
         miss_cnt_d   = '0;
         locked_d     = 1'b0;
         fail_d       = 1'b0;
      end else if (fa.realign_in && state_q != IDLE) begin
         state_d      = CHECK;
         slip_cnt_d   = '0;
         settle_cnt_d = '0;
         match_cnt_d  = '0;
         miss_cnt_d   = '0;
         locked_d     = 1'b0;
         fail_d       = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = CHECK;
            CHECK: begin
               if (match) begin
                  state_d     = VERIFY;
                  match_cnt_d = MW'(1);
               end else if (slip_cnt_q == SLIP_CNT_W'(MAX_SLIPS)) begin
                  state_d = FAIL;
                  fail_d  = 1'b1;
               end else begin
                  // Pulse is registered, so it is high exactly while in SLIP.
                  state_d   = SLIP;
                  bitslip_d = 1'b1;
               end
            end
            SLIP: begin
               state_d      = SETTLE;
               settle_cnt_d = 4'(SETTLE_CYCLES);
               if (slip_cnt_q != SLIP_CNT_W'(MAX_SLIPS))
                  slip_cnt_d = slip_cnt_q + SLIP_CNT_W'(1);
            end
            SETTLE: begin
               if (settle_cnt_q <= 4'd1) begin
                  state_d      = CHECK;
                  settle_cnt_d = '0;
               end else begin
                  settle_cnt_d = settle_cnt_q - 4'd1;
               end
            end
            VERIFY: begin
               if (!match) begin
                  state_d     = CHECK;
                  match_cnt_d = '0;
               end else if (match_cnt_q == MW'(LOCK_COUNT)) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end else begin
                  match_cnt_d = match_cnt_q + MW'(1);
               end
            end
            LOCKED: begin
               if (match) begin
                  miss_cnt_d = '0;
               end else if (miss_cnt_q == LW'(LOSS_COUNT - 1)) begin
                  state_d     = CHECK;
                  locked_d    = 1'b0;
                  slip_cnt_d  = '0;
                  miss_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  miss_cnt_d = miss_cnt_q + LW'(1);
               end
            end
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         slip_cnt_q   <= '0;
         settle_cnt_q <= '0;
         match_cnt_q  <= '0;
         miss_cnt_q   <= '0;
         bitslip_q    <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         slip_cnt_q   <= slip_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         match_cnt_q  <= match_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         bitslip_q    <= bitslip_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
      end
   end

   assign fa.bitslip_out    = bitslip_q;
   assign fa.locked_out     = locked_q;
   assign fa.fail_out       = fail_q;
   assign fa.slip_count_out = slip_cnt_q;

endmodule
